// File: rtl/fp_denorm_pipe.sv
// IEEE-754 binary float to unsigned Q0.OUT_W fixed point, LANES operands per
// transfer, through three registered stages with valid/ready flow control.
module fp_denorm_pipe #(
  parameter int EXP_W = 11,
  parameter int MAN_W = 52,
  parameter int BIAS  = 1023,
  parameter int OUT_W = 64,
  parameter int LANES = 2,
  parameter int CNT_W = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [LANES*(1+EXP_W+MAN_W)-1:0]  in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [LANES*OUT_W-1:0]            out_data,
  output logic [LANES*4-1:0]                out_flags,
  output logic [CNT_W-1:0]                  sat_count,
  input  logic                              sat_clear
);

  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int SIG_W  = MAN_W + 1;
  localparam int SHA_W  = ($clog2(OUT_W) > 4) ? $clog2(OUT_W) : 4;
  localparam int BIAS_W = $clog2(BIAS + 2);
  localparam int MAX_EB = (EXP_W > BIAS_W) ? EXP_W : BIAS_W;
  localparam int SH_W   = ((MAX_EB > SHA_W) ? MAX_EB : SHA_W) + 2;
  localparam int POP_W  = $clog2(LANES + 1);
  localparam logic signed [SH_W-1:0] OUT_LIM = SH_W'(OUT_W);

  typedef enum logic [2:0] {K_INV, K_ZERO, K_OVF, K_UNF, K_NORM} kind_e;

  typedef struct packed {
    kind_e              kind;
    logic [OUT_W-1:0]   mag;
    logic [SHA_W-1:0]   sh;
    logic               sticky;
  } s1_t;

  typedef struct packed {
    kind_e              kind;
    logic [OUT_W-1:0]   mag;
    logic [2:0]         fine;
    logic               sticky;
  } s2_t;

  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic rdy_q;
  logic ready1, ready2, ready3;
  logic [LANES-1:0] ovf_lane;
  logic [POP_W-1:0] inc;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] sat_q, sat_d;

  // A stage may load when empty or when its occupant leaves this cycle.
  assign ready3    = ~v3_q | out_ready;
  assign ready2    = ~v2_q | ready3;
  assign ready1    = ~v1_q | ready2;
  assign in_ready  = rdy_q & ready1;
  assign out_valid = v3_q;
  assign sat_count = sat_q;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    v1_d = v1_q;
    v2_d = v2_q;
    v3_d = v3_q;
    if (ready1) v1_d = in_valid & rdy_q;
    if (ready2) v2_d = v1_q;
    if (ready3) v3_d = v2_q;
  end

  always_comb begin
    inc = '0;
    if (out_valid && out_ready) begin
      for (int i = 0; i < LANES; i++) inc = inc + POP_W'(ovf_lane[i]);
    end
    sum   = {1'b0, sat_q} + (CNT_W+1)'(inc);
    sat_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    if (sat_clear) sat_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q <= 1'b0;
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      sat_q <= '0;
    end else begin
      rdy_q <= 1'b1;
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      v3_q  <= v3_d;
      sat_q <= sat_d;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [W-1:0]             lane;
    logic                     sign;
    logic [EXP_W-1:0]         expo;
    logic [MAN_W-1:0]         man;
    logic [SIG_W+OUT_W-1:0]   wide;
    logic signed [SH_W-1:0]   sh;
    s1_t                      s1_d, s1_q;
    s2_t                      s2_d, s2_q;
    logic [2*OUT_W-1:0]       coarse_ext, fine_ext;
    logic [OUT_W-1:0]         data_d, data_q;
    logic [3:0]               flags_d, flags_q;

    assign lane = in_data[i*W +: W];
    assign sign = lane[W-1];
    assign expo = lane[W-2 -: EXP_W];
    assign man  = lane[MAN_W-1:0];
    // Top OUT_W bits are the left-aligned significand; the rest is what got truncated.
    assign wide = {1'b1, man, {OUT_W{1'b0}}};
    assign sh   = SH_W'(BIAS) - SH_W'(1) - SH_W'(expo);

    always_comb begin
      s1_d.kind   = K_NORM;
      s1_d.mag    = wide[SIG_W+OUT_W-1 -: OUT_W];
      s1_d.sh     = sh[SHA_W-1:0];
      s1_d.sticky = |wide[SIG_W-1:0];
      if (sign || (&expo))       s1_d.kind = K_INV;
      else if (expo == '0)       s1_d.kind = K_ZERO;
      else if (sh[SH_W-1])       s1_d.kind = K_OVF;
      else if (sh >= OUT_LIM)    s1_d.kind = K_UNF;
    end

    assign coarse_ext = {s1_q.mag, {OUT_W{1'b0}}} >> {s1_q.sh[SHA_W-1:3], 3'b000};

    always_comb begin
      s2_d.kind   = s1_q.kind;
      s2_d.mag    = coarse_ext[2*OUT_W-1:OUT_W];
      s2_d.fine   = s1_q.sh[2:0];
      s2_d.sticky = s1_q.sticky | (|coarse_ext[OUT_W-1:0]);
    end

    assign fine_ext = {s2_q.mag, {OUT_W{1'b0}}} >> s2_q.fine;

    always_comb begin
      data_d  = '0;
      flags_d = 4'b0000;
      case (s2_q.kind)
        K_INV:  flags_d = 4'b1000;
        K_OVF: begin
          data_d  = '1;
          flags_d = 4'b0100;
        end
        K_UNF:  flags_d = 4'b0011;
        K_NORM: begin
          data_d  = fine_ext[2*OUT_W-1:OUT_W];
          flags_d = {3'b000, s2_q.sticky | (|fine_ext[OUT_W-1:0])};
        end
        default: ;
      endcase
    end

    // NOTE: internal payload flops carry no reset; the stage valid bits
    // alone decide whether their contents mean anything.
    always_ff @(posedge clk) begin
      if (in_valid && in_ready) s1_q <= s1_d;
      if (v1_q && ready2)       s2_q <= s2_d;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_q  <= '0;
        flags_q <= '0;
      end else if (v2_q && ready3) begin
        data_q  <= data_d;
        flags_q <= flags_d;
      end
    end

    assign out_data[i*OUT_W +: OUT_W] = data_q;
    assign out_flags[i*4 +: 4]        = flags_q;
    assign ovf_lane[i]                = flags_q[2];
  end

endmodule

// File: tb/tb_fp_denorm_pipe.sv
// Directed bench for fp_denorm_pipe at default parameters: conversions, flags,
// saturation counter, backpressure streaming and mid-flight reset.
module tb_fp_denorm_pipe;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [7:0]   out_flags;
  logic [15:0]  sat_count;
  logic         sat_clear;

  int total = 0;
  int bad   = 0;
  int sent;
  int recv;

  always #5 clk = ~clk;

  fp_denorm_pipe #(
    .EXP_W(11), .MAN_W(52), .BIAS(1023), .OUT_W(64), .LANES(2), .CNT_W(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags),
    .sat_count (sat_count),
    .sat_clear (sat_clear)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one transfer into an empty pipe with out_ready high and check it 3 cycles later.
  task automatic run_vec(input string tag, input logic [63:0] l1, input logic [63:0] l0,
                         input logic [63:0] e1, input logic [63:0] e0, input logic [7:0] ef);
    in_valid = 1'b1;
    in_data  = {l1, l0};
    step();
    in_valid = 1'b0;
    in_data  = '0;
    step();
    check($sformatf("%s_lat", tag), out_valid, 1'b0);
    step();
    check($sformatf("%s_valid", tag), out_valid, 1'b1);
    check($sformatf("%s_data", tag), out_data, {e1, e0});
    check($sformatf("%s_flags", tag), out_flags, ef);
  endtask

  function automatic logic [127:0] stream_in(input int k);
    logic [63:0] a;
    logic [63:0] b;
    a = 64'h3FE0000000000000 | (64'(k) << 40);
    b = 64'h3FE0000000000000 | (64'(k + 8) << 40);
    return {b, a};
  endfunction

  function automatic logic [127:0] stream_exp(input int k);
    logic [63:0] a;
    logic [63:0] b;
    a = 64'h8000000000000000 | (64'(k) << 51);
    b = 64'h8000000000000000 | (64'(k + 8) << 51);
    return {b, a};
  endfunction

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    sat_clear = 1'b0;
    step();
    step();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_out_flags", out_flags, '0);
    check("rst_sat_count", sat_count, '0);
    rst = 1'b0;
    step();
    check("rst_in_ready", in_ready, 1'b1);

    run_vec("half_3q", 64'h3FE8000000000000, 64'h3FE0000000000000,
            64'hC000000000000000, 64'h8000000000000000, 8'h00);
    run_vec("lsb_unf", 64'h3BE0000000000000, 64'h3BF0000000000000,
            64'h0000000000000000, 64'h0000000000000001, 8'h30);
    run_vec("inf_sub", 64'h0000000000000001, 64'h7FF0000000000000,
            64'h0000000000000000, 64'h0000000000000000, 8'h08);
    // Lane0 ulp lands at bit 10 (exact); lane1 ulp is shifted out past bit 0.
    run_vec("sticky_a", 64'h3BF0000000000001, 64'h3FD0000000000001,
            64'h0000000000000001, 64'h4000000000000400, 8'h10);
    // sh=12 loses the ulp in the fine stage, sh=16 in the coarse stage.
    run_vec("sticky_b", 64'h3EE0000000000001, 64'h3F20000000000001,
            64'h0000800000000000, 64'h0008000000000000, 8'h11);
    run_vec("below_one", 64'h0000000000000000, 64'h3FEFFFFFFFFFFFFF,
            64'h0000000000000000, 64'hFFFFFFFFFFFFF800, 8'h00);
    step();
    check("sat_zero", sat_count, 16'd0);

    // Overflow on lane0, invalid on lane1, held under backpressure.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = {64'hBFE0000000000000, 64'h3FF0000000000000};
    step();
    in_valid  = 1'b0;
    step();
    step();
    check("ovf_valid", out_valid, 1'b1);
    check("ovf_data", out_data, {64'h0, 64'hFFFFFFFFFFFFFFFF});
    check("ovf_flags", out_flags, 8'h84);
    step();
    check("ovf_hold_valid", out_valid, 1'b1);
    check("ovf_hold_data", out_data, {64'h0, 64'hFFFFFFFFFFFFFFFF});
    check("ovf_hold_flags", out_flags, 8'h84);
    check("ovf_sat_before", sat_count, 16'd0);
    out_ready = 1'b1;
    step();
    check("ovf_sat_after", sat_count, 16'd1);
    check("ovf_drained", out_valid, 1'b0);

    // Clear wins over a concurrent two-lane overflow delivery.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = {64'h3FF0000000000000, 64'h3FF0000000000000};
    step();
    in_valid  = 1'b0;
    step();
    step();
    check("clr_valid", out_valid, 1'b1);
    check("clr_flags", out_flags, 8'h44);
    sat_clear = 1'b1;
    out_ready = 1'b1;
    step();
    sat_clear = 1'b0;
    check("clr_sat", sat_count, 16'd0);
    step();
    check("clr_sat_stays", sat_count, 16'd0);

    // Streaming with a backpressure window on cycles 4..9.
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
      logic acc;
      logic take;
      in_valid  = (sent < 8);
      in_data   = stream_in(sent);
      out_ready = !(cyc >= 4 && cyc <= 9);
      #1;
      if (cyc == 6) begin
        check("stream_in_ready_low", in_ready, 1'b0);
        check("stream_sent_at_stall", 32'(sent), 32'd4);
      end
      if (out_valid) check($sformatf("stream_data_c%0d", cyc), out_data, stream_exp(recv));
      acc  = in_valid && in_ready;
      take = out_valid && out_ready;
      if (acc)  sent++;
      if (take) recv++;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_recv", 32'(recv), 32'd8);
    check("stream_sent", 32'(sent), 32'd8);
    step();
    step();
    check("stream_no_dup", out_valid, 1'b0);

    // Two-lane overflow to make sat_count nonzero, then reset with data in flight.
    run_vec("ovf2", 64'h3FF0000000000000, 64'h3FF0000000000000,
            64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 8'h44);
    step();
    check("ovf2_sat", sat_count, 16'd2);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = stream_in(1);
    step();
    in_data   = stream_in(2);
    step();
    in_valid  = 1'b0;
    step();
    check("pre_rst_valid", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_sat", sat_count, 16'd0);
    check("mid_rst_data", out_data, '0);
    step();
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("post_rst_valid_%0d", c), out_valid, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
